// File: rtl/uart_wb_master_pkg.sv
// Shared constants and state encodings for the UART-to-Wishbone debug bridge.
package uart_wb_master_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h45;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } wb_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_byte_phy.sv
// 8N1 byte PHY: synchronized, half-bit-confirmed receiver and a single-byte transmitter.
module uart_byte_phy
  import uart_wb_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = 104
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic       tx_o,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy
);

  localparam logic [15:0] BIT_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);

  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_t   rx_state_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_sh_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
    end else begin
      rx_s1_q   <= rx_i;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_valid  <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_s2_q) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= HALF_LAST;
          end
        end
        RX_START: begin
          if (rx_cnt_q != '0) begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end else if (rx_s2_q) begin
            rx_state_q <= RX_IDLE;
          end else begin
            rx_state_q <= RX_DATA;
            rx_cnt_q   <= BIT_LAST;
            rx_bit_q   <= '0;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q != '0) begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end else begin
            rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
            rx_cnt_q <= BIT_LAST;
            rx_bit_q <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q != '0) begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end else begin
            rx_state_q <= RX_IDLE;
            if (rx_s2_q) begin
              rx_data  <= rx_sh_q;
              rx_valid <= 1'b1;
            end
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  logic [15:0] tx_cnt_q;
  logic [3:0]  tx_bit_q;
  logic [8:0]  tx_sh_q;

  // tx_bit_q 0..8 walks data+stop; 9 marks the end of the stop bit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_o     <= 1'b1;
      tx_busy  <= 1'b0;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '1;
    end else if (!tx_busy) begin
      if (tx_start) begin
        tx_busy  <= 1'b1;
        tx_o     <= 1'b0;
        tx_sh_q  <= {1'b1, tx_data};
        tx_cnt_q <= BIT_LAST;
        tx_bit_q <= '0;
      end
    end else if (tx_cnt_q != '0) begin
      tx_cnt_q <= tx_cnt_q - 16'd1;
    end else begin
      tx_cnt_q <= BIT_LAST;
      if (tx_bit_q == 4'd9) begin
        tx_busy <= 1'b0;
        tx_o    <= 1'b1;
      end else begin
        tx_o     <= tx_sh_q[0];
        tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
        tx_bit_q <= tx_bit_q + 4'd1;
      end
    end
  end

endmodule

// File: rtl/uart_wb_master.sv
// UART command decoder driving single Wishbone classic cycles.
// Define WB_TIMEOUT_EN to abort unacknowledged cycles after TIMEOUT_CYC clocks.
module uart_wb_master
  import uart_wb_master_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 104,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        ser_rx,
  output logic        ser_tx,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i
);

  if (CLK_DIV < 8 || CLK_DIV > 65535 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("uart_wb_master: CLK_DIV or TIMEOUT_CYC out of range");
  end

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_busy;
  wb_state_t   state_q;
  logic [1:0]  cnt_q, last_q;
  logic        is_wr_q;
  logic [31:0] adr_q, dat_q, rsp_q;
  logic        cyc_q, stb_q, we_q, tx_start_q;

`ifdef WB_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);
  logic [31:0] to_cnt_q;
`endif

  uart_byte_phy #(.CLK_DIV(CLK_DIV)) u_phy (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .rx_i     (ser_rx),
    .tx_o     (ser_tx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_start (tx_start_q),
    .tx_data  (rsp_q[31:24]),
    .tx_busy  (tx_busy)
  );

  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = 4'hF;
  assign wb_we_o  = we_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = stb_q;

  // Response bytes are always taken from rsp_q[31:24]; rsp_q shifts left per byte
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      last_q     <= '0;
      is_wr_q    <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      rsp_q      <= '0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      tx_start_q <= 1'b0;
`ifdef WB_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
`ifdef WB_TIMEOUT_EN
      to_cnt_q <= '0;
`endif
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (rx_valid && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
            is_wr_q <= (rx_data == CMD_WRITE);
            state_q <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (rx_valid) begin
            adr_q <= {adr_q[23:0], rx_data};
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              if (is_wr_q) begin
                state_q <= ST_DATA;
              end else begin
                state_q <= ST_BUS;
                cyc_q   <= 1'b1;
                stb_q   <= 1'b1;
                we_q    <= 1'b0;
              end
            end
          end
        end
        ST_DATA: begin
          if (rx_valid) begin
            dat_q <= {dat_q[23:0], rx_data};
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              state_q <= ST_BUS;
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
              we_q    <= 1'b1;
            end
          end
        end
        ST_BUS: begin
`ifdef WB_TIMEOUT_EN
          to_cnt_q <= to_cnt_q + 32'd1;
`endif
          if (wb_ack_i) begin
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            state_q    <= ST_RESP;
            cnt_q      <= '0;
            tx_start_q <= 1'b1;
            rsp_q      <= is_wr_q ? {RSP_OK, 24'h0} : wb_dat_i;
            last_q     <= is_wr_q ? 2'd0 : 2'd3;
          end
`ifdef WB_TIMEOUT_EN
          else if (to_cnt_q == TO_LAST) begin
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            state_q    <= ST_RESP;
            cnt_q      <= '0;
            tx_start_q <= 1'b1;
            rsp_q      <= {RSP_ERR, 24'h0};
            last_q     <= 2'd0;
          end
`endif
        end
        ST_RESP: begin
          if (tx_start_q) begin
            tx_start_q <= 1'b0;
          end else if (!tx_busy) begin
            if (cnt_q == last_q) begin
              state_q <= ST_IDLE;
            end else begin
              cnt_q      <= cnt_q + 2'd1;
              rsp_q      <= {rsp_q[23:0], 8'h00};
              tx_start_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_wb_master.sv
// Directed bench for uart_wb_master: UART driver, TX capture queue and a simple Wishbone slave.
module tb_uart_wb_master;
  import uart_wb_master_pkg::*;

  localparam int unsigned CLK_DIV     = 16;
  localparam int unsigned TIMEOUT_CYC = 16;
  localparam int          BUDGET      = 4000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ser_rx = 1'b1;
  logic        ser_tx;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i;

  logic [31:0] slave_rdata = 32'h0;
  int unsigned wait_states = 0;
  int unsigned wait_cnt = 0;
  logic        ack_en = 1'b1;
  logic        ack_force = 1'b0;

  int errors = 0;
  int checks = 0;

  uart_wb_master #(.CLK_DIV(CLK_DIV), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .ser_rx   (ser_rx),
    .ser_tx   (ser_tx),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_sel_o (wb_sel_o),
    .wb_we_o  (wb_we_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_ack_i (wb_ack_i)
  );

  always #5 clk = ~clk;

  assign wb_dat_i = slave_rdata;
  assign wb_ack_i = (wb_cyc_o && wb_stb_o && ack_en && wait_cnt == wait_states) || ack_force;

  // Bus observer
  int          ncyc = 0, cyc_clks = 0, rxv_cnt = 0, proto_err = 0;
  logic        cyc_prev = 1'b0, we_at_rise = 1'b0;
  logic [31:0] cap_adr = '0, cap_dat = '0;
  logic        cap_we = 1'b0;
  logic [3:0]  cap_sel = '0;

  always @(posedge clk) begin
    cyc_prev <= wb_cyc_o;
    wait_cnt <= (wb_cyc_o && !wb_ack_i) ? wait_cnt + 1 : 0;
    if (wb_cyc_o && !cyc_prev) begin
      ncyc       <= ncyc + 1;
      we_at_rise <= wb_we_o;
    end
    if (wb_cyc_o) cyc_clks <= cyc_clks + 1;
    if (wb_cyc_o && wb_ack_i) begin
      cap_adr <= wb_adr_o;
      cap_dat <= wb_dat_o;
      cap_we  <= wb_we_o;
      cap_sel <= wb_sel_o;
    end
    if (dut.u_phy.rx_valid) rxv_cnt <= rxv_cnt + 1;
    if ((wb_cyc_o !== wb_stb_o) || (!wb_cyc_o && wb_we_o !== 1'b0) ||
        (wb_cyc_o && cyc_prev && wb_we_o !== we_at_rise))
      proto_err <= proto_err + 1;
  end

  // TX capture: {stop_bit, data}
  logic [8:0] txq[$];
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (ser_tx === 1'b0) begin
        repeat (CLK_DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clk);
          b[i] = ser_tx;
        end
        repeat (CLK_DIV) @(negedge clk);
        txq.push_back({ser_tx, b});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    ser_rx = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    ser_rx = stop;
    repeat (CLK_DIV) @(negedge clk);
    ser_rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [71:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_byte(v[i*8 +: 8], 1'b1);
  endtask

  task automatic wait_tx(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      if (txq.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (ser_tx !== 1'b1) begin errors++; $display("FAIL reset_ser_tx: got %b expected 1", ser_tx); end
    checks++; if (wb_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b expected 0", wb_cyc_o); end
    checks++; if (wb_stb_o !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b expected 0", wb_stb_o); end
    checks++; if (wb_we_o !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", wb_we_o); end
    checks++; if (wb_adr_o !== 32'h0) begin errors++; $display("FAIL reset_adr: got %h expected 0", wb_adr_o); end
    checks++; if (wb_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h expected 0", wb_dat_o); end
    checks++; if (wb_sel_o !== 4'hF) begin errors++; $display("FAIL reset_sel: got %h expected f", wb_sel_o); end
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, ST_IDLE); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write();
    bit ok;
    logic [8:0] r;
    int c0 = ncyc, k0 = cyc_clks, p0 = proto_err;
    ack_en = 1'b1; wait_states = 3; txq.delete();
    send_cmd(72'h57_00001004_DEADBEEF, 9);
    wait_tx(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL write_resp_wait: got %0d bytes expected 1", txq.size()); end
    r = ok ? txq.pop_front() : 9'h0;
    checks++; if (r !== {1'b1, RSP_OK}) begin errors++; $display("FAIL write_resp: got %h expected %h", r, {1'b1, RSP_OK}); end
    checks++; if (ncyc - c0 !== 1) begin errors++; $display("FAIL write_ncyc: got %0d expected 1", ncyc - c0); end
    checks++; if (cyc_clks - k0 !== 4) begin errors++; $display("FAIL write_cyc_len: got %0d expected 4", cyc_clks - k0); end
    checks++; if (cap_adr !== 32'h00001004) begin errors++; $display("FAIL write_adr: got %h expected 00001004", cap_adr); end
    checks++; if (cap_dat !== 32'hDEADBEEF) begin errors++; $display("FAIL write_dat: got %h expected deadbeef", cap_dat); end
    checks++; if (cap_we !== 1'b1 || cap_sel !== 4'hF) begin errors++; $display("FAIL write_we_sel: got %b/%h expected 1/f", cap_we, cap_sel); end
    checks++; if (proto_err !== p0) begin errors++; $display("FAIL write_proto: got %0d errors expected 0", proto_err - p0); end
    repeat (2 * CLK_DIV) @(negedge clk);
  endtask

  task automatic test_read_zero_wait();
    bit ok;
    logic [31:0] d;
    logic [3:0]  s;
    logic [8:0]  r;
    int c0 = ncyc, k0 = cyc_clks, p0 = proto_err;
    ack_en = 1'b1; wait_states = 0; slave_rdata = 32'h12345678; txq.delete();
    send_cmd(72'h52_00000008, 5);
    wait_tx(4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL read_resp_wait: got %0d bytes expected 4", txq.size()); end
    d = '0; s = '0;
    for (int i = 0; i < 4; i++) begin
      r = (txq.size() > 0) ? txq.pop_front() : 9'h0;
      d = {d[23:0], r[7:0]};
      s = {s[2:0], r[8]};
    end
    checks++; if (d !== 32'h12345678 || s !== 4'hF) begin errors++; $display("FAIL read_resp: got %h/%h expected 12345678/f", d, s); end
    checks++; if (ncyc - c0 !== 1) begin errors++; $display("FAIL read_ncyc: got %0d expected 1", ncyc - c0); end
    checks++; if (cyc_clks - k0 !== 1) begin errors++; $display("FAIL read_cyc_len: got %0d expected 1", cyc_clks - k0); end
    checks++; if (cap_adr !== 32'h00000008 || cap_we !== 1'b0) begin errors++; $display("FAIL read_adr_we: got %h/%b expected 00000008/0", cap_adr, cap_we); end
    checks++; if (proto_err !== p0) begin errors++; $display("FAIL read_proto: got %0d errors expected 0", proto_err - p0); end
    repeat (2 * CLK_DIV) @(negedge clk);
  endtask

  task automatic test_unknown_cmd();
    bit ok;
    logic [31:0] d;
    logic [8:0]  r;
    int c0 = ncyc;
    ack_en = 1'b1; wait_states = 1; slave_rdata = 32'hCAFEF00D; txq.delete();
    send_byte(8'h00, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL unk_state: got %0d expected %0d", dut.state_q, ST_IDLE); end
    send_cmd(72'h52_0000000C, 5);
    wait_tx(4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL unk_resp_wait: got %0d bytes expected 4", txq.size()); end
    d = '0;
    for (int i = 0; i < 4; i++) begin
      r = (txq.size() > 0) ? txq.pop_front() : 9'h0;
      d = {d[23:0], r[7:0]};
    end
    checks++; if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL unk_resp: got %h expected cafef00d", d); end
    checks++; if (ncyc - c0 !== 1 || cap_adr !== 32'h0000000C) begin errors++; $display("FAIL unk_bus: got %0d cycles adr %h expected 1 cycle adr 0000000c", ncyc - c0, cap_adr); end
    repeat (2 * CLK_DIV) @(negedge clk);
  endtask

  task automatic test_framing();
    bit ok;
    logic [31:0] d;
    logic [8:0]  r;
    int v0 = rxv_cnt, v1;
    ack_en = 1'b1; wait_states = 0; slave_rdata = 32'hA1B2C3D4; txq.delete();
    @(negedge clk); ser_rx = 1'b0;
    @(negedge clk); ser_rx = 1'b1;
    repeat (2 * CLK_DIV) @(negedge clk);
    checks++; if (rxv_cnt !== v0) begin errors++; $display("FAIL glitch_rx: got %0d bytes expected 0", rxv_cnt - v0); end
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL glitch_state: got %0d expected %0d", dut.state_q, ST_IDLE); end
    send_byte(CMD_READ, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (dut.state_q !== ST_ADDR) begin errors++; $display("FAIL frame_cmd_state: got %0d expected %0d", dut.state_q, ST_ADDR); end
    v1 = rxv_cnt;
    send_byte(8'h77, 1'b0);
    repeat (CLK_DIV) @(negedge clk);
    checks++; if (rxv_cnt !== v1) begin errors++; $display("FAIL badstop_rx: got %0d bytes expected 0", rxv_cnt - v1); end
    checks++; if (dut.state_q !== ST_ADDR || dut.cnt_q !== 2'd0) begin errors++; $display("FAIL badstop_state: got %0d/%0d expected %0d/0", dut.state_q, dut.cnt_q, ST_ADDR); end
    send_cmd(72'h00000010, 4);
    wait_tx(4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL frame_resp_wait: got %0d bytes expected 4", txq.size()); end
    d = '0;
    for (int i = 0; i < 4; i++) begin
      r = (txq.size() > 0) ? txq.pop_front() : 9'h0;
      d = {d[23:0], r[7:0]};
    end
    checks++; if (d !== 32'hA1B2C3D4 || cap_adr !== 32'h00000010) begin errors++; $display("FAIL frame_read: got %h adr %h expected a1b2c3d4 adr 00000010", d, cap_adr); end
    repeat (2 * CLK_DIV) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok, seen;
    logic [8:0] r;
    int c0;
    ack_en = 1'b0; wait_states = 0; txq.delete();
    send_cmd(72'h57_00000020_11223344, 9);
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (wb_cyc_o === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstbus_cyc_rise: got 0 expected 1"); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || wb_we_o !== 1'b0) begin errors++; $display("FAIL rstbus_bus: got cyc=%b stb=%b we=%b expected 0 0 0", wb_cyc_o, wb_stb_o, wb_we_o); end
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL rstbus_state: got %0d expected %0d", dut.state_q, ST_IDLE); end
    rst = 1'b0; ack_en = 1'b1;
    repeat (4) @(negedge clk);

    slave_rdata = 32'h0;
    send_cmd(72'h52_00000000, 5);
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (ser_tx === 1'b0) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL rsttx_start: got 0 expected 1"); end
    repeat (3 * CLK_DIV) @(negedge clk);
    checks++; if (ser_tx !== 1'b0) begin errors++; $display("FAIL rsttx_midbit: got %b expected 0", ser_tx); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ser_tx !== 1'b1) begin errors++; $display("FAIL rsttx_line: got %b expected 1", ser_tx); end
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL rsttx_state: got %0d expected %0d", dut.state_q, ST_IDLE); end
    rst = 1'b0;
    repeat (12 * CLK_DIV) @(negedge clk);
    txq.delete();

    c0 = ncyc; wait_states = 1;
    send_cmd(72'h57_00000030_A55A0FF0, 9);
    wait_tx(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL postrst_wait: got %0d bytes expected 1", txq.size()); end
    r = ok ? txq.pop_front() : 9'h0;
    checks++; if (r !== {1'b1, RSP_OK}) begin errors++; $display("FAIL postrst_resp: got %h expected %h", r, {1'b1, RSP_OK}); end
    checks++; if (ncyc - c0 !== 1 || cap_adr !== 32'h00000030 || cap_dat !== 32'hA55A0FF0) begin errors++; $display("FAIL postrst_bus: got %0d/%h/%h expected 1/00000030/a55a0ff0", ncyc - c0, cap_adr, cap_dat); end
    repeat (2 * CLK_DIV) @(negedge clk);
  endtask

`ifdef WB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok, seen;
    logic [8:0] r;
    int c0 = ncyc, k0 = cyc_clks;
    ack_en = 1'b0; txq.delete();
    send_cmd(72'h52_00000040, 5);
    seen = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (ncyc != c0 && wb_cyc_o === 1'b0) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL to_abort: got 0 expected 1"); end
    ack_force = 1'b1;
    repeat (4) @(negedge clk);
    ack_force = 1'b0;
    checks++; if (cyc_clks - k0 !== int'(TIMEOUT_CYC)) begin errors++; $display("FAIL to_cyc_len: got %0d expected %0d", cyc_clks - k0, TIMEOUT_CYC); end
    wait_tx(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_resp_wait: got %0d bytes expected 1", txq.size()); end
    repeat (30 * CLK_DIV) @(negedge clk);
    checks++; if (txq.size() !== 1) begin errors++; $display("FAIL to_resp_count: got %0d expected 1", txq.size()); end
    r = (txq.size() > 0) ? txq.pop_front() : 9'h0;
    checks++; if (r !== {1'b1, RSP_ERR}) begin errors++; $display("FAIL to_resp: got %h expected %h", r, {1'b1, RSP_ERR}); end
    checks++; if (ncyc - c0 !== 1 || dut.state_q !== ST_IDLE) begin errors++; $display("FAIL to_late_ack: got %0d cycles state %0d expected 1 cycle state %0d", ncyc - c0, dut.state_q, ST_IDLE); end
    ack_en = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read_zero_wait();
    test_unknown_cmd();
    test_framing();
    test_reset_mid();
`ifdef WB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_wb_master.md
# uart_wb_master

Serial-to-Wishbone bridge. Receives framed commands on a UART line, decodes them, and issues single Wishbone classic master cycles (read or write) into the SoC bus. It then returns a status byte or read data over the UART transmit line. It sits at the debug/host-access edge of the design and drives the same bus the peripheral slaves (UART, SPI, GPIO) hang on.

## Interface
Parameters:
- CLK_DIV, 104: clock cycles per UART bit; legal range 8..65535.
- TIMEOUT_CYC, 1024: bus-cycle timeout in clocks. Used only when the timeout feature is compiled in.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- ser_rx  in  1  UART receive, idle high, async to clock.
- ser_tx  out  1  UART transmit, idle high.
- wb_adr_o  out  32  byte address.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_sel_o  out  4  byte enables; always 4'hF.
- wb_we_o  out  1  write enable.
- wb_cyc_o  out  1  cycle valid.
- wb_stb_o  out  1  strobe.
- wb_ack_i  in  1  slave acknowledge.

## Operation
- Frame format is 8N1, LSB first.
- Command byte 0x57 ('W'): 4 address bytes, then 4 data bytes, then bus write. Response is 0x4B ('K').
- Command byte 0x52 ('R'): 4 address bytes, then bus read. Response is the 4 data bytes.
- Multi-byte fields are big-endian (MSB first) in both directions.
- Any other command byte is discarded; the FSM stays in IDLE.
- RX path:
  - 2-FF synchronizer on ser_rx.
  - Start detected on a falling edge and confirmed at half-bit (CLK_DIV/2). A high sample there aborts the frame.
  - Data bits are sampled every CLK_DIV clocks.
  - The stop bit must be 1. A bad stop bit drops the byte (no rx_valid pulse).
- FSM states and transitions:
  - IDLE → ADDR on a valid command.
  - ADDR collects 4 bytes; byte counter runs 0..3. → DATA if write, → BUS if read.
  - DATA collects 4 bytes → BUS.
  - BUS asserts cyc/stb/we/adr/dat. Holds until ack. On ack: latch wb_dat_i for reads, deassert cyc/stb, → RESP.
  - RESP queues 1 or 4 bytes to TX, waits for each to finish → IDLE.
- Bytes received while in BUS or RESP are ignored (half-duplex protocol).
- wb_adr_o and wb_dat_o are shift registers, filled MSB first.
- TX serializer:
  - Start bit, 8 data bits, stop bit; each bit is CLK_DIV clocks.
  - Signals busy until the stop bit completes.
  - A new byte may load on the cycle after busy falls.

## Timing
- Reset values: ser_tx=1, wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_adr_o=0, wb_dat_o=0, wb_sel_o=4'hF. FSM returns to IDLE.
- Reset mid-cycle drops cyc/stb on the next edge. A TX byte in flight is truncated and the line is forced high.
- cyc and stb rise together on the first clock in BUS and fall on the clock after ack is sampled high.
- Zero-wait slave (ack in the first BUS cycle): the bus cycle lasts exactly 1 clock.
- wb_we_o is stable for the whole cycle. It is 0 outside BUS.
- The first TX start bit begins 1 clock after the bus cycle ends.
- A received byte is visible to the FSM 1 clock after the stop-bit sample.

## Configuration
- WB_TIMEOUT_EN defined:
  - A counter runs during BUS.
  - If TIMEOUT_CYC clocks pass without ack: drop cyc/stb and send the single byte 0x45 ('E') in place of the normal response. This applies to both reads and writes.
  - A late ack after the abort is ignored.
- WB_TIMEOUT_EN undefined: BUS waits for ack indefinitely and no counter is built.

## Structure
- Shared package holds:
  - Command constants CMD_WRITE=8'h57 and CMD_READ=8'h52.
  - Response constants RSP_OK=8'h4B and RSP_ERR=8'h45.
  - The FSM state enum.
- One sub-module, uart_byte_phy, contains the RX synchronizer/deserializer and the TX serializer.
  - Outputs: rx_data[7:0], rx_valid pulse, tx_busy.
  - Input: tx_start with tx_data[7:0].
- The top level holds the FSM, shift registers, bus master and optional timeout.

## Test plan
- Write: send 57 00 00 10 04 DE AD BE EF with slave ack after 3 wait states → one cycle with adr=0x00001004, dat=0xDEADBEEF, we=1, sel=F; ser_tx returns 0x4B.
- Read, zero-wait: send 52 00 00 00 08, slave returns 0x12345678 with ack in the first BUS clock → cyc high 1 clock, we=0; ser_tx returns 12 34 56 78.
- Unknown command: send 0x00, then a valid read → the first byte is ignored, the read completes normally, exactly one bus cycle.
- Framing errors: 1-clock low glitch on ser_rx → no byte received. Byte with stop bit=0 → dropped, FSM state unchanged.
- Reset mid-operation: assert wb_rst_i while in BUS and mid-TX → next clock cyc=stb=0, ser_tx=1, FSM in IDLE; a following write succeeds.
- With WB_TIMEOUT_EN and TIMEOUT_CYC=16: issue a read with no ack → cyc drops after 16 clocks, ser_tx returns 0x45; a late ack is ignored.
